// File: rtl/multipath_pkg.sv
// Shared types and defaults for the multi-channel delay-path scanner.
package multipath_pkg;

  localparam int unsigned NUM_CH_DEF  = 8;
  localparam int unsigned RES_W_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EMIT,
    DONE
  } state_t;

  // Lowest bit of channel k's slice within the packed result bus.
  function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned res_w);
    return k * res_w;
  endfunction

endpackage

// File: rtl/multipath_chan_mux.sv
// Registered NUM_CH:1 mux of result+fin; out-of-range selects read as zero.
module multipath_chan_mux
  import multipath_pkg::*;
#(
  parameter  int unsigned NUM_CH = NUM_CH_DEF,
  parameter  int unsigned RES_W  = RES_W_DEF,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*RES_W-1:0] ch_result,
  input  logic [NUM_CH-1:0]       ch_fin,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  output logic [RES_W-1:0]        sel_result,
  output logic                    sel_fin,
  output logic [RES_W-1:0]        q_result,
  output logic                    q_fin,
  output logic [SEL_W-1:0]        q_sel
);

  always_comb begin
    sel_result = '0;
    sel_fin    = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(sel) == k) begin
        sel_result = ch_result[chan_lsb(k, RES_W) +: RES_W];
        sel_fin    = ch_fin[k];
      end
    end
  end

  // When not tracking, result/sel hold but fin drops so a stale level never reads as valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_result <= '0;
      q_fin    <= 1'b0;
      q_sel    <= '0;
    end else if (en) begin
      q_result <= sel_result;
      q_fin    <= sel_fin;
      q_sel    <= sel;
    end else begin
      q_fin    <= 1'b0;
    end
  end

endmodule

// File: rtl/multipath_scan.sv
// Manual channel selector / autonomous per-channel scanner with timeout.
// Optional max-hold tracking enabled by MULTIPATH_SCAN_MAXHOLD_EN.
module multipath_scan
  import multipath_pkg::*;
#(
  parameter  int unsigned NUM_CH  = NUM_CH_DEF,
  parameter  int unsigned RES_W   = RES_W_DEF,
  parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned SEL_W   = $clog2(NUM_CH)
) (
  input  logic                    clk250,
  input  logic                    rst_n,
  input  logic [NUM_CH*RES_W-1:0] ch_result,
  input  logic [NUM_CH-1:0]       ch_fin,
  input  logic [SEL_W-1:0]        SW,
  input  logic                    mode,
  input  logic                    start,
  output logic [RES_W-1:0]        result,
  output logic                    fin,
  output logic [SEL_W-1:0]        result_ch,
  output logic                    timeout_err,
  output logic                    busy,
  output logic                    scan_done
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
  ,
  output logic [RES_W-1:0]        max_result,
  output logic [SEL_W-1:0]        max_ch
`endif
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(NUM_CH - 1);

  state_t             state, state_d;
  logic [SEL_W-1:0]   ch_idx, ch_idx_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [RES_W-1:0]   cap_result, cap_result_d;
  logic               scan_fin, scan_fin_d;
  logic [SEL_W-1:0]   scan_ch, scan_ch_d;
  logic               timeout_d, busy_d, done_d;
  logic               view_manual, view_manual_d;

  logic [SEL_W-1:0]   mux_sel;
  logic               mux_en;
  logic [RES_W-1:0]   mux_result, mux_q_result;
  logic               mux_fin, mux_q_fin;
  logic [SEL_W-1:0]   mux_q_sel;

`ifdef MULTIPATH_SCAN_MAXHOLD_EN
  logic [RES_W-1:0]   max_result_d;
  logic [SEL_W-1:0]   max_ch_d;
`endif

  assign mux_sel = (state == IDLE) ? SW : ch_idx;
  assign mux_en  = (state == IDLE) && !mode;

  multipath_chan_mux #(
    .NUM_CH (NUM_CH),
    .RES_W  (RES_W)
  ) u_mux (
    .clk        (clk250),
    .rst_n      (rst_n),
    .ch_result  (ch_result),
    .ch_fin     (ch_fin),
    .sel        (mux_sel),
    .en         (mux_en),
    .sel_result (mux_result),
    .sel_fin    (mux_fin),
    .q_result   (mux_q_result),
    .q_fin      (mux_q_fin),
    .q_sel      (mux_q_sel)
  );

  // Outputs show whichever register set was last updated: manual mux or scan capture.
  assign result    = view_manual ? mux_q_result : cap_result;
  assign fin       = view_manual ? mux_q_fin    : scan_fin;
  assign result_ch = view_manual ? mux_q_sel    : scan_ch;

  always_comb begin
    state_d       = state;
    ch_idx_d      = ch_idx;
    cnt_d         = cnt;
    cap_result_d  = cap_result;
    scan_fin_d    = 1'b0;
    scan_ch_d     = scan_ch;
    timeout_d     = 1'b0;
    busy_d        = busy;
    done_d        = 1'b0;
    view_manual_d = view_manual;
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
    max_result_d  = max_result;
    max_ch_d      = max_ch;
`endif
    case (state)
      IDLE: begin
        if (!mode) begin
          view_manual_d = 1'b1;
        end else if (start) begin
          state_d       = WAIT;
          ch_idx_d      = '0;
          cnt_d         = '0;
          busy_d        = 1'b1;
          view_manual_d = 1'b0;
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
          max_result_d  = '0;
          max_ch_d      = '0;
`endif
        end
      end
      WAIT: begin
        if (mux_fin) begin
          cap_result_d = mux_result;
          scan_fin_d   = 1'b1;
          scan_ch_d    = ch_idx;
          state_d      = EMIT;
        end else if (cnt == CNT_LAST) begin
          cap_result_d = '0;
          scan_fin_d   = 1'b1;
          scan_ch_d    = ch_idx;
          timeout_d    = 1'b1;
          state_d      = EMIT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      EMIT: begin
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
        if (!timeout_err && (cap_result > max_result)) begin
          max_result_d = cap_result;
          max_ch_d     = ch_idx;
        end
`endif
        if (ch_idx == CH_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          ch_idx_d = ch_idx + 1'b1;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk250) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch_idx      <= '0;
      cnt         <= '0;
      cap_result  <= '0;
      scan_fin    <= 1'b0;
      scan_ch     <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      view_manual <= 1'b0;
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
      max_result  <= '0;
      max_ch      <= '0;
`endif
    end else begin
      state       <= state_d;
      ch_idx      <= ch_idx_d;
      cnt         <= cnt_d;
      cap_result  <= cap_result_d;
      scan_fin    <= scan_fin_d;
      scan_ch     <= scan_ch_d;
      timeout_err <= timeout_d;
      busy        <= busy_d;
      scan_done   <= done_d;
      view_manual <= view_manual_d;
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
      max_result  <= max_result_d;
      max_ch      <= max_ch_d;
`endif
    end
  end

endmodule

// File: tb/tb_multipath_scan.sv
// Randomized self-checking bench for multipath_scan against a slot-schedule model.
module tb_multipath_scan;

  localparam int unsigned NCH  = 6;
  localparam int unsigned RW   = 16;
  localparam int unsigned TO   = 16;
  localparam int unsigned SW_W = 3;
  localparam int unsigned BIG  = 100000;

  logic                 clk250 = 1'b0;
  logic                 rst_n;
  logic [NCH*RW-1:0]    ch_result;
  logic [NCH-1:0]       ch_fin;
  logic [SW_W-1:0]      SW;
  logic                 mode, start;
  logic [RW-1:0]        result;
  logic                 fin;
  logic [SW_W-1:0]      result_ch;
  logic                 timeout_err, busy, scan_done;
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
  logic [RW-1:0]        max_result;
  logic [SW_W-1:0]      max_ch;
`endif

  always #2 clk250 = ~clk250;

  multipath_scan #(
    .NUM_CH  (NCH),
    .RES_W   (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk250      (clk250),
    .rst_n       (rst_n),
    .ch_result   (ch_result),
    .ch_fin      (ch_fin),
    .SW          (SW),
    .mode        (mode),
    .start       (start),
    .result      (result),
    .fin         (fin),
    .result_ch   (result_ch),
    .timeout_err (timeout_err),
    .busy        (busy),
    .scan_done   (scan_done)
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
    ,
    .max_result  (max_result),
    .max_ch      (max_ch)
`endif
  );

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  logic [RW-1:0] val[NCH];
  int unsigned  fdel[NCH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_results();
    for (int unsigned k = 0; k < NCH; k++) ch_result[k*RW +: RW] = val[k];
  endtask

  task automatic manual_step(input logic [SW_W-1:0] s, input logic [NCH-1:0] f);
    logic [RW-1:0] er;
    logic          ef;
    mode = 1'b0; start = 1'b0; SW = s; ch_fin = f;
    drive_results();
    @(posedge clk250); @(negedge clk250);
    er = '0; ef = 1'b0;
    if (s < NCH) begin
      er = val[s];
      ef = f[s];
    end
    chk("man_result", result, er);
    chk("man_fin", fin, ef);
    chk("man_ch", result_ch, s);
    chk("man_busy", busy, 0);
    chk("man_to", timeout_err, 0);
  endtask

  // Model: channel k's slot begins at edge s; it is captured at the first edge >= s at which
  // its fin is high, unless TO edges pass first. fin (absolute edge fdel[k]) stays high once up.
  task automatic run_scan(input bit abort4);
    int unsigned   cap[NCH], sstart[NCH];
    bit            tmo[NCH];
    logic [RW-1:0] er[NCH];
    int unsigned   s, e, done_n, kk;
    bit            efin;
    logic [RW-1:0] emax;
    int unsigned   ech;
    s = 1;
    for (int unsigned k = 0; k < NCH; k++) begin
      sstart[k] = s;
      e = (fdel[k] > s) ? fdel[k] : s;
      if (e - s <= TO - 1) begin
        cap[k] = e; tmo[k] = 1'b0; er[k] = val[k];
      end else begin
        cap[k] = s + TO - 1; tmo[k] = 1'b1; er[k] = '0;
      end
      s = cap[k] + 2;
    end
    done_n = cap[NCH-1] + 1;
    emax = '0; ech = 0;
    for (int unsigned k = 0; k < NCH; k++)
      if (!tmo[k] && er[k] > emax) begin emax = er[k]; ech = k; end

    mode = 1'b1; start = 1'b1;
    drive_results();
    for (int unsigned k = 0; k < NCH; k++) ch_fin[k] = (fdel[k] == 0);
    for (int unsigned n = 0; n <= done_n + 2; n++) begin
      @(posedge clk250); @(negedge clk250);
      efin = 1'b0; kk = 0;
      for (int unsigned k = 0; k < NCH; k++) if (cap[k] == n) begin efin = 1'b1; kk = k; end
      chk("scan_fin", fin, efin);
      if (efin) begin
        chk("scan_result", result, er[kk]);
        chk("scan_ch", result_ch, kk);
        chk("scan_to", timeout_err, tmo[kk]);
      end else begin
        chk("scan_to_quiet", timeout_err, 0);
      end
      chk("scan_busy", busy, n <= done_n);
      chk("scan_done", scan_done, n == done_n);
      if (n > cap[NCH-1]) begin
        chk("hold_result", result, er[NCH-1]);
        chk("hold_ch", result_ch, NCH - 1);
      end
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
      if (n == done_n) begin
        chk("max_result", max_result, emax);
        chk("max_ch", max_ch, ech);
      end
`endif
      if (abort4 && n == sstart[4]) begin
        rst_n = 1'b0;
        @(posedge clk250); @(negedge clk250);
        chk("rst_busy", busy, 0);
        chk("rst_fin", fin, 0);
        chk("rst_result", result, 0);
        chk("rst_ch", result_ch, 0);
        chk("rst_to", timeout_err, 0);
        chk("rst_done", scan_done, 0);
        rst_n = 1'b1;
        return;
      end
      if (n + 1 <= done_n) begin
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
        mode  = 1'b1;
      end
      for (int unsigned k = 0; k < NCH; k++) ch_fin[k] = (n + 1 >= fdel[k]);
    end
  endtask

  task automatic randomize_scan();
    for (int unsigned k = 0; k < NCH; k++) begin
      val[k]  = RW'($urandom);
      fdel[k] = ($urandom_range(0, 3) == 0) ? BIG : $urandom_range(0, 70);
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; start = 1'b0; SW = '0; ch_fin = '0; ch_result = '0;
    for (int unsigned k = 0; k < NCH; k++) begin val[k] = '0; fdel[k] = 0; end
    repeat (2) @(posedge clk250);
    @(negedge clk250);
    chk("reset_result", result, 0);
    chk("reset_fin", fin, 0);
    chk("reset_ch", result_ch, 0);
    chk("reset_to", timeout_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", scan_done, 0);
`ifdef MULTIPATH_SCAN_MAXHOLD_EN
    chk("reset_max", max_result, 0);
    chk("reset_max_ch", max_ch, 0);
`endif
    rst_n = 1'b1;

    for (int unsigned k = 0; k < NCH; k++) val[k] = RW'(k * 100);
    manual_step(3'd5, '1);
    manual_step(3'd7, '1);
    manual_step(3'd6, '1);
    repeat (20) begin
      for (int unsigned k = 0; k < NCH; k++) val[k] = RW'($urandom);
      manual_step(SW_W'($urandom_range(0, 7)), NCH'($urandom));
    end

    for (int unsigned k = 0; k < NCH; k++) begin val[k] = RW'(k * 100); fdel[k] = 0; end
    run_scan(1'b0);
    manual_step(3'd2, NCH'($urandom));

    fdel[3] = BIG;
    run_scan(1'b0);

    val = '{16'd10, 16'd70, 16'd30, 16'd70, 16'd5, 16'd90};
    for (int unsigned k = 0; k < NCH; k++) fdel[k] = 0;
    fdel[5] = BIG;
    run_scan(1'b0);

    for (int unsigned k = 0; k < NCH; k++) begin val[k] = RW'($urandom); fdel[k] = $urandom_range(0, 30); end
    run_scan(1'b1);
    run_scan(1'b0);

    repeat (8) begin
      randomize_scan();
      run_scan(1'b0);
    end
    manual_step(3'd4, NCH'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
